mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_DATA_STREAK, default 4: consecutive data grants allowed while a fetch waits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have fetch-port ports:
- if_req in 1
- if_addr in 32
- if_gnt out 1
- if_rvalid out 1
- if_rdata out 32
REQ-005 SHALL have data-port ports:
- d_req in 1
- d_we in 1
- d_size in 2: 00 byte, 01 half, 10 word
- d_uns in 1: zero-extend loads
- d_addr in 32
- d_wdata in 32
- d_gnt out 1
- d_rvalid out 1
- d_rdata out 32
REQ-006 SHALL have memory-side ports, all meeting the shared byte-addressed data memory:
- memory_write out 1
- memory_size out 2
- memory_addr out 32
- memory_data_in out 32
- memory_data_out in 32: valid the cycle after a read is issued
REQ-007 SHALL have ports if_err out 1 and d_err out 1, misalignment pulses.

Function
REQ-008 SHALL grant at most one request per cycle; if_gnt/d_gnt are combinational from the reqs, the owner state and the streak counter.
REQ-009 SHALL track owner state IDLE/FETCH/DATA, updated each edge to the port granted that cycle, or IDLE if neither was granted.
REQ-010 SHALL give the data port priority, except that it grants fetch when if_req=1 and streak==MAX_DATA_STREAK.
REQ-011 SHALL increment streak on a data grant while if_req=1, and clear it on a fetch grant or when if_req=0; streak saturates at MAX_DATA_STREAK.
REQ-012 SHALL drive memory_* combinationally from the granted port in the grant cycle; the fetch port always uses memory_size=2'b10 and memory_write=0.
REQ-013 SHALL drive memory_write=0, memory_size=2'b10, memory_addr=0 and memory_data_in=0 when nothing is granted.
REQ-014 SHALL require requesters to hold req, addr, size and wdata stable until gnt; behaviour otherwise is undefined.
REQ-015 SHALL assert the matching rvalid for exactly one cycle, the cycle after each read grant (latency 1); back-to-back reads are allowed.
REQ-016 SHALL complete writes at the grant edge and SHALL NOT produce any rvalid for them.
REQ-017 SHALL present if_rdata=memory_data_out, and d_rdata extended by the registered size and d_uns:
- byte: bits [7:0], sign- or zero-extended
- half: bits [15:0], sign- or zero-extended
- word: as-is
REQ-018 SHALL grant d_size=2'b11 with memory_write=0 and return d_rvalid with d_rdata=0.
REQ-019 SHALL hold rdata outputs at their last value while rvalid=0.

Reset
REQ-020 SHALL, while rst=1, force state=IDLE, streak=0, all gnt/rvalid/err=0, rdata outputs=0 and memory_write=0.
REQ-021 SHALL discard a read granted in the cycle rst asserts; no rvalid appears after rst deasserts.

Configuration
REQ-022 SHALL support macro MEM_ARB_MISALIGN_CHECK_EN.
- Defined: a data access with d_addr not aligned to d_size, or a fetch with if_addr[0]=1, is still granted but issues no memory access (memory_write=0, memory_addr=0), pulses the matching err in the cycle after the grant, and returns rvalid with rdata=0 for reads.
- Undefined: no check is made, and if_err/d_err are tied 0.

Structure
REQ-023 SHALL take from shared package mem_arb_pkg the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the owner-state enum and the data-width constant.
REQ-024 SHALL place the load extension logic in sub-module load_extend (inputs data, size, uns; output 32-bit).

Verification
REQ-025 SHALL cover: if_req=1 and d_req=1, d_we=0, d_addr=0x10 with mem[0x10..0x13]=0x11223344 -> d_gnt; next cycle d_rvalid=1, d_rdata=0x11223344; if_gnt the cycle after.
REQ-026 SHALL cover: d_size=00, d_uns=0 at a byte holding 0x80 -> d_rdata=0xFFFFFF80; repeated with d_uns=1 -> 0x00000080.
REQ-027 SHALL cover: d_req held for 6 cycles with if_req=1 and MAX_DATA_STREAK=4 -> 4 d_gnt, then 1 if_gnt, then d_gnt resumes.
REQ-028 SHALL cover: a word write of 0xDEADBEEF to 0x20, then a read of 0x20 -> no rvalid for the write; the read returns 0xDEADBEEF.
REQ-029 SHALL cover: rst asserted in the read-grant cycle -> no rvalid after rst deasserts; streak=0.
REQ-030 SHALL cover, with MEM_ARB_MISALIGN_CHECK_EN: word read at 0x22 -> memory_write=0, memory_addr=0; next cycle d_err=1, d_rvalid=1, d_rdata=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Size encodings, owner-state enum, data width and alignment helper.
package mem_arb_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DATA
    } owner_e;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lsb
    );
        return (size == SZ_HALF && lsb[0]) ||
               (size == SZ_WORD && lsb != 2'b00);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_load_extend.sv
// Load extension: selects byte/half/word and sign- or zero-extends.
// The reserved size returns zero.
module load_extend
    import mem_arb_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        size,
    input  logic              uns,
    output logic [DATA_W-1:0] ext
);

    logic w_sb;
    logic w_sh;

    assign w_sb = ~uns & data[7];
    assign w_sh = ~uns & data[15];

    always_comb begin
        ext = '0;
        unique case (size)
            SZ_BYTE: ext = {{(DATA_W-8){w_sb}}, data[7:0]};
            SZ_HALF: ext = {{(DATA_W-16){w_sh}}, data[15:0]};
            SZ_WORD: ext = data;
            default: ext = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto one byte-addressed data memory.
// Optional alignment checking: define MEM_ARB_MISALIGN_CHECK_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_uns,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              memory_write,
    output logic [1:0]        memory_size,
    output logic [DATA_W-1:0] memory_addr,
    output logic [DATA_W-1:0] memory_data_in,
    input  logic [DATA_W-1:0] memory_data_out,
    output logic              if_err,
    output logic              d_err
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    owner_e            r_state;
    logic [SW-1:0]     r_streak;
    logic              r_if_rvalid;
    logic              r_d_rvalid;
    logic              r_if_zero;
    logic              r_d_zero;
    logic [1:0]        r_d_size;
    logic              r_d_uns;
    logic              r_if_err;
    logic              r_d_err;
    logic [DATA_W-1:0] r_if_hold;
    logic [DATA_W-1:0] r_d_hold;

    logic              w_fetch_turn;
    logic              w_d_bad;
    logic              w_d_read;
    logic              w_if_mis;
    logic              w_d_mis;
    logic [DATA_W-1:0] w_ext;

`ifdef MEM_ARB_MISALIGN_CHECK_EN
    assign w_if_mis = if_addr[0];
    assign w_d_mis  = misaligned(d_size, d_addr[1:0]);
`else
    assign w_if_mis = 1'b0;
    assign w_d_mis  = 1'b0;
`endif

    // A full streak can only follow a data grant, so owner==DATA qualifies it.
    assign w_fetch_turn = if_req && r_state == ST_DATA &&
                          r_streak == STREAK_MAX;

    assign d_gnt  = !rst && d_req && !w_fetch_turn;
    assign if_gnt = !rst && if_req && (!d_req || w_fetch_turn);

    assign w_d_bad  = d_size == SZ_BAD;
    assign w_d_read = !d_we || w_d_bad;

    always_comb begin
        memory_write   = 1'b0;
        memory_size    = SZ_WORD;
        memory_addr    = '0;
        memory_data_in = '0;
        if (d_gnt) begin
            memory_write   = !w_d_read && !w_d_mis;
            memory_size    = w_d_bad ? SZ_WORD : d_size;
            memory_addr    = w_d_mis ? '0 : d_addr;
            memory_data_in = d_wdata;
        end else if (if_gnt) begin
            memory_addr = w_if_mis ? '0 : if_addr;
        end
    end

    load_extend u_ext (
        .data (memory_data_out),
        .size (r_d_size),
        .uns  (r_d_uns),
        .ext  (w_ext)
    );

    assign if_rvalid = r_if_rvalid;
    assign d_rvalid  = r_d_rvalid;
    assign if_err    = r_if_err;
    assign d_err     = r_d_err;

    always_comb begin
        if_rdata = r_if_hold;
        if (r_if_rvalid)
            if_rdata = r_if_zero ? '0 : memory_data_out;
    end

    always_comb begin
        d_rdata = r_d_hold;
        if (r_d_rvalid)
            d_rdata = r_d_zero ? '0 : w_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_streak    <= '0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_zero   <= 1'b0;
            r_d_zero    <= 1'b0;
            r_d_size    <= SZ_WORD;
            r_d_uns     <= 1'b0;
            r_if_err    <= 1'b0;
            r_d_err     <= 1'b0;
            r_if_hold   <= '0;
            r_d_hold    <= '0;
        end else begin
            if (d_gnt)
                r_state <= ST_DATA;
            else if (if_gnt)
                r_state <= ST_FETCH;
            else
                r_state <= ST_IDLE;

            if (if_gnt || !if_req)
                r_streak <= '0;
            else if (d_gnt && r_streak != STREAK_MAX)
                r_streak <= r_streak + SW'(1);

            r_if_rvalid <= if_gnt;
            r_d_rvalid  <= d_gnt && w_d_read;
            r_if_err    <= if_gnt && w_if_mis;
            r_d_err     <= d_gnt && w_d_mis;

            if (if_gnt)
                r_if_zero <= w_if_mis;
            if (d_gnt && w_d_read) begin
                r_d_size <= d_size;
                r_d_uns  <= d_uns;
                r_d_zero <= w_d_mis || w_d_bad;
            end

            if (r_if_rvalid)
                r_if_hold <= if_rdata;
            if (r_d_rvalid)
                r_d_hold <= d_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte memory model
// and read-data scoreboards for both ports.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = 2'b10;
    logic        d_uns = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        memory_write;
    logic [1:0]  memory_size;
    logic [31:0] memory_addr, memory_data_in;
    logic [31:0] memory_data_out;
    logic        if_err, d_err;

    int total = 0;
    int bad = 0;
    logic [31:0] dq[$];
    logic [31:0] iq[$];
    logic [7:0]  mem [0:511];
    logic [8:0]  ma;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_uns(d_uns),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .memory_write(memory_write), .memory_size(memory_size),
        .memory_addr(memory_addr), .memory_data_in(memory_data_in),
        .memory_data_out(memory_data_out),
        .if_err(if_err), .d_err(d_err)
    );

    assign ma = memory_addr[8:0];

    // Byte-addressed little-endian memory, read data one cycle later.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
            mem[9'h010] <= 8'h44; mem[9'h011] <= 8'h33;
            mem[9'h012] <= 8'h22; mem[9'h013] <= 8'h11;
            mem[9'h100] <= 8'h13;
            mem[9'h030] <= 8'h80;
        end else if (memory_write) begin
            mem[ma] <= memory_data_in[7:0];
            if (memory_size != 2'b00) mem[ma + 9'd1] <= memory_data_in[15:8];
            if (memory_size == 2'b10) begin
                mem[ma + 9'd2] <= memory_data_in[23:16];
                mem[ma + 9'd3] <= memory_data_in[31:24];
            end
        end
        memory_data_out <= {mem[ma + 9'd3], mem[ma + 9'd2],
                            mem[ma + 9'd1], mem[ma]};
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (d_rvalid) begin
            if (dq.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
            else chk("d_rdata", d_rdata, dq.pop_front());
        end
        if (if_rvalid) begin
            if (iq.size() == 0) chk("if_rvalid_unexpected", 32'd1, 32'd0);
            else chk("if_rdata", if_rdata, iq.pop_front());
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic dread(input string tag, input logic [31:0] a,
                         input logic [1:0] sz, input logic u,
                         input logic [31:0] exp);
        d_req = 1'b1; d_we = 1'b0; d_addr = a; d_size = sz; d_uns = u;
        @(negedge clk);
        chk({tag, "_gnt"}, {31'd0, d_gnt}, 32'd1);
        chk({tag, "_mwr"}, {31'd0, memory_write}, 32'd0);
        dq.push_back(exp);
        nxt();
        d_req = 1'b0;
    endtask

    logic pat [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        // Reset state with both requests raised
        if_req = 1'b1; d_req = 1'b1; d_addr = 32'h10;
        repeat (2) @(negedge clk);
        chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
        chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
        chk("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mwr", {31'd0, memory_write}, 32'd0);
        chk("rst_err", {30'd0, if_err, d_err}, 32'd0);
        if_req = 1'b0; d_req = 1'b0;
        nxt();
        rst = 1'b0;

        // Data beats fetch, fetch follows
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h10;
        @(negedge clk);
        chk("A_d_gnt", {31'd0, d_gnt}, 32'd1);
        chk("A_if_gnt", {31'd0, if_gnt}, 32'd0);
        chk("A_maddr", memory_addr, 32'h10);
        dq.push_back(32'h11223344);
        nxt();
        d_req = 1'b0;
        @(negedge clk);
        chk("A_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("A_if_gnt2", {31'd0, if_gnt}, 32'd1);
        chk("A_msize", {30'd0, memory_size}, 32'd2);
        chk("A_maddr2", memory_addr, 32'h100);
        iq.push_back(32'h00000013);
        nxt();
        if_req = 1'b0;

        // Byte loads, signed then unsigned
        dread("B_sx", 32'h30, 2'b00, 1'b0, 32'hFFFFFF80);
        dread("B_zx", 32'h30, 2'b00, 1'b1, 32'h00000080);

        // Streak limit: 4 data, 1 fetch, data again
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_size = 2'b10; d_uns = 1'b0; d_addr = 32'h10;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("C_d_gnt%0d", i), {31'd0, d_gnt}, {31'd0, pat[i]});
            chk($sformatf("C_if_gnt%0d", i), {31'd0, if_gnt}, {31'd0, !pat[i]});
            if (pat[i]) dq.push_back(32'h11223344);
            else iq.push_back(32'h00000013);
            nxt();
        end
        if_req = 1'b0; d_req = 1'b0;

        // Reserved size reads as zero
        dread("E_bad", 32'h10, 2'b11, 1'b0, 32'h0);

        // Word write, then read back, then hold
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10;
        d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("D_wr_gnt", {31'd0, d_gnt}, 32'd1);
        chk("D_wr_mwr", {31'd0, memory_write}, 32'd1);
        chk("D_wr_mdin", memory_data_in, 32'hDEADBEEF);
        nxt();
        d_we = 1'b0;
        @(negedge clk);
        chk("D_wr_no_rvalid", {31'd0, d_rvalid}, 32'd0);
        dq.push_back(32'hDEADBEEF);
        nxt();
        d_req = 1'b0;
        nxt();
        @(negedge clk);
        chk("D_hold_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("D_hold_rdata", d_rdata, 32'hDEADBEEF);
        chk("D_idle_maddr", memory_addr, 32'h0);
        nxt();

        // Misaligned word read
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h22;
        @(negedge clk);
        chk("G_gnt", {31'd0, d_gnt}, 32'd1);
        chk("G_mwr", {31'd0, memory_write}, 32'd0);
`ifdef MEM_ARB_MISALIGN_CHECK_EN
        chk("G_maddr", memory_addr, 32'h0);
        dq.push_back(32'h0);
`else
        chk("G_maddr", memory_addr, 32'h22);
        dq.push_back(32'h0000DEAD);
`endif
        nxt();
        d_req = 1'b0;
        @(negedge clk);
        chk("G_rvalid", {31'd0, d_rvalid}, 32'd1);
`ifdef MEM_ARB_MISALIGN_CHECK_EN
        chk("G_d_err", {31'd0, d_err}, 32'd1);
`else
        chk("G_d_err", {31'd0, d_err}, 32'd0);
`endif
        chk("G_if_err", {31'd0, if_err}, 32'd0);
        nxt();
        @(negedge clk);
        chk("G_err_pulse", {31'd0, d_err}, 32'd0);
        nxt();

        // Reset during a read grant
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_size = 2'b10; d_addr = 32'h10;
        repeat (2) begin
            @(negedge clk);
            chk("F_pre_gnt", {31'd0, d_gnt}, 32'd1);
            dq.push_back(32'h11223344);
            nxt();
        end
        @(negedge clk);
        chk("F_gnt_rst_cycle", {31'd0, d_gnt}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("F_rst_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
        chk("F_rst_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("F_rst_rdata", d_rdata, 32'd0);
        chk("F_rst_mwr", {31'd0, memory_write}, 32'd0);
        nxt();
        nxt();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) chk("F_no_rvalid", {31'd0, d_rvalid}, 32'd0);
            chk($sformatf("F_d_gnt%0d", i), {31'd0, d_gnt}, {31'd0, pat[i]});
            chk($sformatf("F_if_gnt%0d", i), {31'd0, if_gnt}, {31'd0, !pat[i]});
            if (pat[i]) dq.push_back(32'h11223344);
            else iq.push_back(32'h00000013);
            nxt();
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) nxt();
        chk("drain_dq", dq.size(), 32'd0);
        chk("drain_iq", iq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
